// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and
// the instruction constants the stage recognises or resets to.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_pc_plus4.sv
// Sequential-PC adder; wraps modulo 2^32 with no carry out.
module pc_plus4 (
    input  logic [31:0] pc_i,
    output logic [31:0] pc_plus4_o
);

    assign pc_plus4_o = pc_i + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory
// combinationally and registers one instruction per cycle into IF/ID,
// with stall, redirect/flush and EBREAK halt handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branchTaken_i,
    input  logic [31:0] branchTarget_i,
    input  logic        idReady_i,
    output logic [31:0] imemAddr_o,
    input  logic [31:0] imemRdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcPlus4_o,
    output logic        valid_o,
    output logic        halted_o,
    output logic        misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_pc_plus4_q, id_pc_plus4_d;
    logic         valid_q, valid_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  pc_next;
    logic [31:0]  redirect_pc;

    // Redirect targets are forced to word alignment; the low bits only
    // feed the misalign pulse.
    assign redirect_pc = {branchTarget_i[31:2], 2'b00};

    pc_plus4 u_pc_plus4 (
        .pc_i       (pc_q),
        .pc_plus4_o (pc_next)
    );

    // Next-state logic: redirect beats fetch/stall; HALT only drains IF/ID.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        valid_d       = valid_q;
        misalign_d    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (branchTaken_i) begin
                    pc_d       = redirect_pc;
                    valid_d    = 1'b0;
                    misalign_d = |branchTarget_i[1:0];
                end else if (!valid_q || idReady_i) begin
                    instr_d       = imemRdata_i;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_next;
                    valid_d       = 1'b1;
                    pc_d          = pc_next;
                    if (imemRdata_i == EBREAK_INSTR) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (branchTaken_i) begin
                    pc_d       = redirect_pc;
                    valid_d    = 1'b0;
                    misalign_d = |branchTarget_i[1:0];
                    state_d    = ST_RUN;
                end else if (valid_q && idReady_i) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and IF/ID registers; reset discards any in-flight instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            id_pc_q       <= 32'h0000_0000;
            id_pc_plus4_q <= 32'h0000_0000;
            valid_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            valid_q       <= valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imemAddr_o = pc_q;
    assign instr_o    = instr_q;
    assign pc_o       = id_pc_q;
    assign pcPlus4_o  = id_pc_plus4_q;
    assign valid_o    = valid_q;
    assign halted_o   = (state_q == ST_HALT);
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async reset
// check, then randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic        valid;
    logic        halted;
    logic        misalign;

    int tests  = 0;
    int errors = 0;
    bit rand_mode = 0;

    fetch_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .branchTaken_i  (br),
        .branchTarget_i (tgt),
        .idReady_i      (rdy),
        .imemAddr_o     (imem_addr),
        .imemRdata_i    (imem_rdata),
        .instr_o        (instr),
        .pc_o           (pc),
        .pcPlus4_o      (pc_p4),
        .valid_o        (valid),
        .halted_o       (halted),
        .misalign_o     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: address-derived words, EBREAK at chosen spots.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!rand_mode && a == 32'h10) return EBREAK;
        if (rand_mode && a[5:2] == 4'hF) return EBREAK;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          br;
        logic [31:0] tgt;
        bit          rdy;
        bit          chk;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] pp4;
        logic [31:0] instr;
        logic [31:0] addr;
        bit          mis;
        bit          halt;
    } vec_t;

    vec_t vecs[20];

    // Behavioural model of the stage's visible state
    logic [31:0] m_pc, m_instr, m_pcout;
    bit          m_valid, m_halt, m_mis, m_boot;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pcout = 32'h0;
        m_valid = 0; m_halt = 0; m_mis = 0; m_boot = 1;
    endtask

    task automatic model_step(input bit b, input logic [31:0] t, input bit r);
        if (m_boot) begin
            m_boot = 0;
            m_mis  = 0;
            return;
        end
        m_mis = b && (t[1:0] != 2'b00);
        if (b) begin
            m_pc = t & 32'hFFFF_FFFC;
            m_valid = 0;
            m_halt = 0;
        end else if (m_halt) begin
            if (r) m_valid = 0;
        end else if (!m_valid || r) begin
            m_instr = mem_word(m_pc);
            m_pcout = m_pc;
            m_valid = 1;
            m_halt  = (m_instr == EBREAK);
            m_pc    = m_pc + 32'd4;
        end
    endtask

    initial begin
        // br, tgt, rdy, chk, valid, pc, pp4, instr, addr, mis, halt
        vecs[0]  = '{0, 32'h0,         1, 0, 0, 32'h0,         32'h0,   32'h0,         32'h0,         0, 0};
        vecs[1]  = '{0, 32'h0,         1, 1, 1, 32'h0,         32'h4,   32'hA5A5_0000, 32'h4,         0, 0};
        vecs[2]  = '{0, 32'h0,         1, 1, 1, 32'h4,         32'h8,   32'hA5A5_0004, 32'h8,         0, 0};
        vecs[3]  = '{0, 32'h0,         1, 1, 1, 32'h8,         32'hC,   32'hA5A5_0008, 32'hC,         0, 0};
        vecs[4]  = '{0, 32'h0,         0, 1, 1, 32'h8,         32'hC,   32'hA5A5_0008, 32'hC,         0, 0};
        vecs[5]  = '{0, 32'h0,         0, 1, 1, 32'h8,         32'hC,   32'hA5A5_0008, 32'hC,         0, 0};
        vecs[6]  = '{0, 32'h0,         0, 1, 1, 32'h8,         32'hC,   32'hA5A5_0008, 32'hC,         0, 0};
        vecs[7]  = '{0, 32'h0,         1, 1, 1, 32'hC,         32'h10,  32'hA5A5_000C, 32'h10,        0, 0};
        vecs[8]  = '{1, 32'h102,       0, 0, 0, 32'h0,         32'h0,   32'h0,         32'h100,       1, 0};
        vecs[9]  = '{0, 32'h0,         0, 1, 1, 32'h100,       32'h104, 32'hA5A5_0100, 32'h104,       0, 0};
        vecs[10] = '{1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,         32'h0,   32'h0,         32'hFFFF_FFFC, 0, 0};
        vecs[11] = '{0, 32'h0,         1, 1, 1, 32'hFFFF_FFFC, 32'h0,   32'h5A5A_FFFC, 32'h0,         0, 0};
        vecs[12] = '{0, 32'h0,         1, 1, 1, 32'h0,         32'h4,   32'hA5A5_0000, 32'h4,         0, 0};
        vecs[13] = '{1, 32'h10,        1, 0, 0, 32'h0,         32'h0,   32'h0,         32'h10,        0, 0};
        vecs[14] = '{0, 32'h0,         0, 1, 1, 32'h10,        32'h14,  EBREAK,        32'h14,        0, 1};
        vecs[15] = '{0, 32'h0,         0, 1, 1, 32'h10,        32'h14,  EBREAK,        32'h14,        0, 1};
        vecs[16] = '{0, 32'h0,         1, 0, 0, 32'h0,         32'h0,   32'h0,         32'h14,        0, 1};
        vecs[17] = '{0, 32'h0,         1, 0, 0, 32'h0,         32'h0,   32'h0,         32'h14,        0, 1};
        vecs[18] = '{1, 32'h40,        0, 0, 0, 32'h0,         32'h0,   32'h0,         32'h40,        0, 0};
        vecs[19] = '{0, 32'h0,         1, 1, 1, 32'h40,        32'h44,  32'hA5A5_0040, 32'h44,        0, 0};

        rst = 0; br = 0; tgt = 0; rdy = 0;
        #1 rst = 1;
        #1;
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pp4", pc_p4, 32'h0);
        chk("rst_halt", {31'b0, halted}, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'h0);
        step(); step();
        rst = 0;

        for (int i = 0; i < 20; i++) begin
            br = vecs[i].br; tgt = vecs[i].tgt; rdy = vecs[i].rdy;
            step();
            $display("[TB] vec %0d br=%0d tgt=%h rdy=%0d -> valid=%0d pc=%h instr=%h addr=%h mis=%0d halt=%0d",
                     i, br, tgt, rdy, valid, pc, instr, imem_addr, misalign, halted);
            chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].mis});
            chk($sformatf("v%0d_halt", i), {31'b0, halted}, {31'b0, vecs[i].halt});
            if (vecs[i].chk) begin
                chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
                chk($sformatf("v%0d_pp4", i), pc_p4, vecs[i].pp4);
                chk($sformatf("v%0d_instr", i), instr, vecs[i].instr);
            end
        end

        // Asynchronous reset mid-cycle while an instruction is valid
        br = 0; rdy = 1;
        chk("pre_arst_valid", {31'b0, valid}, 32'h1);
        #2 rst = 1;
        #1;
        $display("[TB] async reset -> valid=%0d addr=%h instr=%h", valid, imem_addr, instr);
        chk("arst_valid", {31'b0, valid}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_instr", instr, NOP);
        chk("arst_pc", pc, 32'h0);
        step(); step();

        // Randomized traffic against the model
        rand_mode = 1;
        model_reset();
        rst = 0;
        for (int c = 0; c < 400; c++) begin
            br  = (!m_boot) && ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       tgt = 32'($urandom_range(0, 255));
                default: tgt = $urandom;
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            model_step(br, tgt, rdy);
            step();
            $display("[TB] rnd %0d br=%0d tgt=%h rdy=%0d -> valid=%0d pc=%h addr=%h halt=%0d mis=%0d",
                     c, br, tgt, rdy, valid, pc, imem_addr, halted, misalign);
            chk("rnd_valid", {31'b0, valid}, {31'b0, m_valid});
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_halt", {31'b0, halted}, {31'b0, m_halt});
            chk("rnd_mis", {31'b0, misalign}, {31'b0, m_mis});
            if (m_valid) begin
                chk("rnd_pc", pc, m_pcout);
                chk("rnd_pp4", pc_p4, m_pcout + 32'd4);
                chk("rnd_instr", instr, m_instr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
